// File: rtl/draw_rect_engine_if.sv
// draw_rect_engine_if: bundles the processor store snoop port, the framebuffer
// valid/ready pixel port and the engine's status outputs.
// master = processor/framebuffer side, slave = fill engine.
interface draw_rect_engine_if #(
   parameter int FB_AW   = 19,
   parameter int COLOR_W = 8
);
   logic               MemWrite;
   logic [31:0]        DataAdr;
   logic [31:0]        WriteData;
   logic               fb_valid;
   logic               fb_ready;
   logic [FB_AW-1:0]   fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic               busy;
   logic               done;
   logic [31:0]        status;

   modport master (
      output MemWrite, DataAdr, WriteData, fb_ready,
      input  fb_valid, fb_addr, fb_data, busy, done, status
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData, fb_ready,
      output fb_valid, fb_addr, fb_data, busy, done, status
   );
endinterface

// File: rtl/draw_rect_engine.sv
// draw_rect_engine: memory-mapped rectangle fill engine. Snoops processor
// stores into a small register window and streams one framebuffer write per
// pixel of the clipped rectangle, row-major.
// Optional feature: define DRAW_ABORT_EN to enable CTRL bit1 abort and
// status[1]; when undefined no abort logic exists.
module draw_rect_engine #(
   parameter logic [31:0] BASE_ADR = 32'h0000_1000,
   parameter int          SCREEN_W = 640,
   parameter int          SCREEN_H = 480,
   parameter int          FB_AW    = 19,
   parameter int          COLOR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   draw_rect_engine_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

   localparam logic [9:0]       MAX_X  = 10'(SCREEN_W - 1);
   localparam logic [9:0]       MAX_Y  = 10'(SCREEN_H - 1);
   localparam logic [9:0]       SCR_W  = 10'(SCREEN_W);
   localparam logic [9:0]       SCR_H  = 10'(SCREEN_H);
   localparam logic [FB_AW-1:0] ROW_SZ = FB_AW'(SCREEN_W);

   state_t             r_state;
   logic [9:0]         r_x0, r_y0, r_x1, r_y1;
   logic [COLOR_W-1:0] r_color;
   logic [9:0]         r_x1c, r_y1c, r_cx, r_cy;
   logic [FB_AW-1:0]   r_rowBase, r_fbAddr;
   logic [COLOR_W-1:0] r_fbData;
   logic               r_fbValid, r_done;

   logic               w_wrX0, w_wrY0, w_wrX1, w_wrY1, w_wrColor, w_wrCtrl;
   logic               w_start, w_busy, w_hs, w_empty, w_abort, w_aborted;
   logic [9:0]         w_x1c, w_y1c;
   logic [FB_AW-1:0]   w_rowBaseInit, w_nextRowBase;
   logic               w_unused;

   assign w_wrX0    = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h00);
   assign w_wrY0    = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h04);
   assign w_wrX1    = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h08);
   assign w_wrY1    = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h0C);
   assign w_wrColor = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h10);
   assign w_wrCtrl  = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'h14);
   assign w_start   = w_wrCtrl && bus.WriteData[0];

   assign w_busy    = (r_state != IDLE);
   assign w_hs      = r_fbValid && bus.fb_ready;

   // Clip the far corner to the screen; the near corner is range-checked in SETUP.
   assign w_x1c     = (r_x1 > MAX_X) ? MAX_X : r_x1;
   assign w_y1c     = (r_y1 > MAX_Y) ? MAX_Y : r_y1;
   assign w_empty   = (r_x0 > r_x1c) || (r_y0 > r_y1c) || (r_x0 >= SCR_W) || (r_y0 >= SCR_H);

   assign w_rowBaseInit = FB_AW'(r_y0) * ROW_SZ;
   assign w_nextRowBase = r_rowBase + ROW_SZ;

   // Upper store-data bits carry no register content.
   assign w_unused = ^bus.WriteData;

`ifdef DRAW_ABORT_EN
   logic r_abortReq, r_aborted;
   logic w_abortWr;

   assign w_abortWr = w_wrCtrl && bus.WriteData[1] && w_busy;
   assign w_abort   = w_abortWr || r_abortReq;
   assign w_aborted = r_aborted;

   // Remember an abort request until the command ends; record that it ended by abort.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_abortReq <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         if (r_state == IDLE)
            r_abortReq <= 1'b0;
         else if (w_abortWr)
            r_abortReq <= 1'b1;

         if (r_state == IDLE && w_start)
            r_aborted <= 1'b0;
         else if ((r_state == SETUP && w_abort) ||
                  (r_state == DRAW && w_abort && (w_hs || !r_fbValid)))
            r_aborted <= 1'b1;
      end
   end
`else
   assign w_abort   = 1'b0;
   assign w_aborted = 1'b0;
`endif

   // Coordinate and colour registers; frozen while a command is running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_color <= '0;
      end else if (r_state == IDLE) begin
         if (w_wrX0)    r_x0    <= bus.WriteData[9:0];
         if (w_wrY0)    r_y0    <= bus.WriteData[9:0];
         if (w_wrX1)    r_x1    <= bus.WriteData[9:0];
         if (w_wrY1)    r_y1    <= bus.WriteData[9:0];
         if (w_wrColor) r_color <= bus.WriteData[COLOR_W-1:0];
      end
   end

   // Fill sequencer: latch bounds, walk the rectangle row-major, pulse done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_x1c     <= '0;
         r_y1c     <= '0;
         r_cx      <= '0;
         r_cy      <= '0;
         r_rowBase <= '0;
         r_fbAddr  <= '0;
         r_fbData  <= '0;
         r_fbValid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_x1c    <= w_x1c;
                  r_y1c    <= w_y1c;
                  r_fbData <= r_color;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               if (w_empty || w_abort) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cx      <= r_x0;
                  r_cy      <= r_y0;
                  r_rowBase <= w_rowBaseInit;
                  r_fbAddr  <= w_rowBaseInit + FB_AW'(r_x0);
                  r_fbValid <= 1'b1;
                  r_state   <= DRAW;
               end
            end
            DRAW: begin
               if (w_hs) begin
                  if (w_abort) begin
                     r_fbValid <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= DONE;
                  end else if (r_cx != r_x1c) begin
                     r_cx     <= r_cx + 10'd1;
                     r_fbAddr <= r_fbAddr + FB_AW'(1);
                  end else if (r_cy != r_y1c) begin
                     r_cx      <= r_x0;
                     r_cy      <= r_cy + 10'd1;
                     r_rowBase <= w_nextRowBase;
                     r_fbAddr  <= w_nextRowBase + FB_AW'(r_x0);
                  end else begin
                     r_fbValid <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= DONE;
                  end
               end else if (w_abort && !r_fbValid) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.fb_valid = r_fbValid;
   assign bus.fb_addr  = r_fbAddr;
   assign bus.fb_data  = r_fbData;
   assign bus.busy     = w_busy;
   assign bus.done     = r_done;
   assign bus.status   = {30'b0, w_aborted, w_busy};

endmodule

// File: tb/tb_draw_rect_engine.sv
// tb_draw_rect_engine: table-driven checks of the rectangle fill engine plus
// hand-written sequences for backpressure, busy writes, reset and abort.
module tb_draw_rect_engine;

   typedef struct {
      int x0, y0, x1, y1;
      int color;
      int expCount;
      int expFirst;
      int expLast;
      int expLat;
   } vec_t;

   logic clk;
   logic reset;
   draw_rect_engine_if bus ();

   draw_rect_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nVec = 0;
   int nMiss = 0;
   int cycleCnt = 0;
   int readyMode = 0;
   int startEdge = 0;
   int stallErr = 0;
   int stallCnt = 0;
   logic prevStall = 1'b0;
   logic prevValid = 1'b0;
   logic [18:0] prevAddr = '0;
   logic [7:0]  prevData = '0;
   int accAddr[$];
   int accData[$];
   int doneCyc[$];
   int validRise[$];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count active edges; after edge k cycleCnt == k.
   always @(posedge clk) cycleCnt++;

   // Framebuffer ready pattern: 0 always ready, 1 toggling, 2 held low.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       bus.fb_ready = 1'b1;
         1:       bus.fb_ready = (bus.fb_ready === 1'b1) ? 1'b0 : 1'b1;
         default: bus.fb_ready = 1'b0;
      endcase
   end

   // Passive monitor: log accepted pixels, done pulses, first-valid cycles, stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         prevStall = 1'b0;
         prevValid = 1'b0;
      end else begin
         if (prevStall && bus.fb_valid && (bus.fb_addr != prevAddr || bus.fb_data != prevData))
            stallErr++;
         if (bus.fb_valid && !prevValid)
            validRise.push_back(cycleCnt + 1);
         if (bus.fb_valid && bus.fb_ready) begin
            accAddr.push_back(int'(bus.fb_addr));
            accData.push_back(int'(bus.fb_data));
         end
         if (bus.fb_valid && !bus.fb_ready)
            stallCnt++;
         if (bus.done)
            doneCyc.push_back(cycleCnt + 1);
         prevStall = bus.fb_valid && !bus.fb_ready;
         prevValid = bus.fb_valid;
         prevAddr  = bus.fb_addr;
         prevData  = bus.fb_data;
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nVec++;
      if (actual != expected) begin
         nMiss++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One processor store; called and returns 1 time unit after a rising edge.
   task automatic regWrite(input int offset, input int data);
      bus.DataAdr   = 32'h0000_1000 + offset;
      bus.WriteData = data;
      bus.MemWrite  = 1'b1;
      @(posedge clk); #1;
      bus.MemWrite  = 1'b0;
   endtask

   task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1, input int color);
      regWrite(32'h00, x0);
      regWrite(32'h04, y0);
      regWrite(32'h08, x1);
      regWrite(32'h0C, y1);
      regWrite(32'h10, color);
      regWrite(32'h14, 1);
      startEdge = cycleCnt;
   endtask

   task automatic waitDone(input string name, input int base, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (doneCyc.size() > base) break;
         @(posedge clk); #1;
      end
      if (doneCyc.size() <= base)
         checkOutput({name, "_doneTimeout"}, 0, 1);
   endtask

   task automatic waitPixels(input int base, input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (accAddr.size() - base >= n) break;
         @(posedge clk); #1;
      end
      if (accAddr.size() - base < n)
         checkOutput("pixelTimeout", accAddr.size() - base, n);
   endtask

   task automatic checkData(input string name, input int base, input int color);
      int errs = 0;
      for (int k = base; k < accData.size(); k++)
         if (accData[k] != color) errs++;
      checkOutput(name, errs, 0);
   endtask

   vec_t vecs[8];
   int   expSeq[6];

   initial begin
      int aBase, dBase, rBase, sBase, cBase, got;

      vecs[0] = '{2,   3,   4,    4,   8'h1F, 6, 1922,   2564,   8};
      vecs[1] = '{636, 479, 700,  900, 8'hA5, 4, 307196, 307199, 6};
      vecs[2] = '{10,  0,   5,    0,   8'h11, 0, 0,      0,      2};
      vecs[3] = '{0,   0,   0,    0,   8'h01, 1, 0,      0,      3};
      vecs[4] = '{639, 0,   1000, 2,   8'h7E, 3, 639,    1919,   5};
      vecs[5] = '{5,   480, 10,   500, 8'h22, 0, 0,      0,      2};
      vecs[6] = '{640, 0,   700,  0,   8'h33, 0, 0,      0,      2};
      vecs[7] = '{0,   10,  3,    11,  8'hC3, 8, 6400,   7043,   10};
      expSeq  = '{1922, 1923, 1924, 2562, 2563, 2564};

      reset         = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.DataAdr   = '0;
      bus.WriteData = '0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("rst_fbValid", bus.fb_valid, 0);
      checkOutput("rst_fbAddr",  bus.fb_addr, 0);
      checkOutput("rst_fbData",  bus.fb_data, 0);
      checkOutput("rst_busy",    bus.busy, 0);
      checkOutput("rst_done",    bus.done, 0);
      checkOutput("rst_status",  bus.status, 0);

      reset = 1'b1;
      @(posedge clk); #1;

      // Table-driven rectangles with fb_ready held high.
      readyMode = 0;
      for (int v = 0; v < 8; v++) begin
         aBase = accAddr.size();
         dBase = doneCyc.size();
         rBase = validRise.size();
         applyStimulus(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].color);
         checkOutput($sformatf("v%0d_statusBusy", v), bus.status, 1);
         waitDone($sformatf("v%0d", v), dBase, 300);
         got = accAddr.size() - aBase;
         checkOutput($sformatf("v%0d_count", v), got, vecs[v].expCount);
         if (vecs[v].expCount > 0 && got > 0) begin
            checkOutput($sformatf("v%0d_first", v), accAddr[aBase], vecs[v].expFirst);
            checkOutput($sformatf("v%0d_last", v), accAddr[accAddr.size()-1], vecs[v].expLast);
            checkOutput($sformatf("v%0d_validLat", v),
                        (validRise.size() > rBase) ? validRise[rBase] - startEdge : -1, 2);
         end else begin
            checkOutput($sformatf("v%0d_noValid", v), validRise.size() - rBase, 0);
         end
         checkData($sformatf("v%0d_data", v), aBase, vecs[v].color);
         checkOutput($sformatf("v%0d_doneLat", v),
                     (doneCyc.size() > dBase) ? doneCyc[dBase] - startEdge : -1, vecs[v].expLat);
         checkOutput($sformatf("v%0d_doneOnce", v), doneCyc.size() - dBase, 1);
         checkOutput($sformatf("v%0d_idleStatus", v), bus.status, 0);
      end

      // Backpressure: ready toggles every cycle, sequence and stability must hold.
      readyMode = 1;
      aBase = accAddr.size();
      dBase = doneCyc.size();
      sBase = stallErr;
      cBase = stallCnt;
      applyStimulus(2, 3, 4, 4, 8'h1F);
      waitDone("toggle", dBase, 300);
      checkOutput("toggle_count", accAddr.size() - aBase, 6);
      for (int k = 0; k < 6; k++)
         checkOutput($sformatf("toggle_addr%0d", k),
                     (aBase + k < accAddr.size()) ? accAddr[aBase + k] : -1, expSeq[k]);
      checkData("toggle_data", aBase, 8'h1F);
      checkOutput("toggle_stable", stallErr - sBase, 0);
      checkOutput("toggle_stalled", (stallCnt - cBase) > 0, 1);

      // Register and start writes while busy, and unmapped writes, are ignored.
      readyMode = 2;
      aBase = accAddr.size();
      dBase = doneCyc.size();
      applyStimulus(1, 1, 2, 1, 8'h2C);
      regWrite(32'h00, 0);
      regWrite(32'h04, 0);
      regWrite(32'h08, 639);
      regWrite(32'h0C, 479);
      regWrite(32'h10, 8'h55);
      regWrite(32'h14, 1);
      regWrite(32'h18, 1);
      checkOutput("busyWr_stillStalled", accAddr.size() - aBase, 0);
      readyMode = 0;
      waitDone("busyWr", dBase, 300);
      checkOutput("busyWr_count", accAddr.size() - aBase, 2);
      checkOutput("busyWr_first", (accAddr.size() > aBase) ? accAddr[aBase] : -1, 641);
      checkOutput("busyWr_last", accAddr[accAddr.size()-1], 642);
      checkData("busyWr_data", aBase, 8'h2C);
      checkOutput("busyWr_doneOnce", doneCyc.size() - dBase, 1);
      regWrite(32'h1018, 1);
      regWrite(32'h0FFC, 1);
      checkOutput("unmapped_noStart", bus.busy, 0);
      aBase = accAddr.size();
      dBase = doneCyc.size();
      regWrite(32'h14, 1);
      startEdge = cycleCnt;
      waitDone("restart", dBase, 300);
      checkOutput("restart_count", accAddr.size() - aBase, 2);
      checkOutput("restart_first", (accAddr.size() > aBase) ? accAddr[aBase] : -1, 641);
      checkData("restart_data", aBase, 8'h2C);
      checkOutput("restart_doneLat", (doneCyc.size() > dBase) ? doneCyc[dBase] - startEdge : -1, 4);

      // Reset asserted mid-draw returns to idle immediately.
      aBase = accAddr.size();
      applyStimulus(0, 0, 99, 99, 8'h66);
      waitPixels(aBase, 37, 300);
      reset = 1'b0;
      #1;
      checkOutput("midRst_fbValid", bus.fb_valid, 0);
      checkOutput("midRst_busy",    bus.busy, 0);
      checkOutput("midRst_status",  bus.status, 0);
      checkOutput("midRst_fbAddr",  bus.fb_addr, 0);
      checkOutput("midRst_count",   accAddr.size() - aBase, 37);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      aBase = accAddr.size();
      dBase = doneCyc.size();
      applyStimulus(7, 2, 7, 2, 8'h33);
      waitDone("postRst", dBase, 300);
      checkOutput("postRst_count", accAddr.size() - aBase, 1);
      checkOutput("postRst_addr", (accAddr.size() > aBase) ? accAddr[aBase] : -1, 1287);
      checkData("postRst_data", aBase, 8'h33);
      checkOutput("postRst_doneLat", (doneCyc.size() > dBase) ? doneCyc[dBase] - startEdge : -1, 3);

      // Abort request part-way through a large fill.
      aBase = accAddr.size();
      dBase = doneCyc.size();
      applyStimulus(0, 0, 99, 99, 8'h44);
      waitPixels(aBase, 10, 300);
      regWrite(32'h14, 2);
      waitDone("abort", dBase, 12000);
      got = accAddr.size() - aBase;
`ifdef DRAW_ABORT_EN
      checkOutput("abort_countRange", (got >= 10 && got <= 11), 1);
      checkOutput("abort_status", bus.status, 2);
      dBase = doneCyc.size();
      applyStimulus(1, 1, 1, 1, 8'h05);
      checkOutput("abort_clearedOnStart", bus.status, 1);
      waitDone("abortAfter", dBase, 300);
      checkOutput("abortAfter_status", bus.status, 0);
`else
      checkOutput("noAbort_count", got, 10000);
      checkOutput("noAbort_last", accAddr[accAddr.size()-1], 63459);
      checkOutput("noAbort_status", bus.status, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/draw_rect_engine.md
# draw_rect_engine

Memory-mapped 2D fill engine that sits directly downstream of the processor's data-store port. It snoops `MemWrite`/`DataAdr`/`WriteData`, holds a small register file of rectangle coordinates and colour, and on a start command streams one framebuffer write per pixel over a valid/ready port into the VGA framebuffer. It lets software fill a clipped axis-aligned rectangle with a single store instead of one store per pixel.

## Interface
- `BASE_ADR`, 32'h0000_1000, byte address of register 0; window is BASE_ADR..BASE_ADR+0x14.
- `SCREEN_W`, 640, pixels per row.
- `SCREEN_H`, 480, rows.
- `FB_AW`, 19, framebuffer address width (pixel index).
- `COLOR_W`, 8, pixel data width.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: processor store strobe.
- `DataAdr` in 32: processor store address.
- `WriteData` in 32: processor store data.
- `fb_valid` out 1: pixel write request.
- `fb_ready` in 1: framebuffer accepts the pixel on `fb_valid && fb_ready`.
- `fb_addr` out FB_AW: pixel index, `y*SCREEN_W + x`.
- `fb_data` out COLOR_W: pixel colour.
- `busy` out 1: high whenever the FSM is not IDLE.
- `done` out 1: one-cycle pulse when a command finishes.
- `status` out 32: `{30'b0, aborted, busy}`.

## Operation
- Register write: `MemWrite && DataAdr == BASE_ADR+off`. Offsets: 0x00 X0, 0x04 Y0, 0x08 X1, 0x0C Y1 (each WriteData[9:0]), 0x10 COLOR (WriteData[COLOR_W-1:0]), 0x14 CTRL (bit0 start, bit1 abort).
- Writes to 0x00–0x10 while busy are ignored. A start while busy is ignored. Other addresses are ignored.
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE: a start goes to SETUP. Clipped bounds are latched: x1c = min(X1, SCREEN_W-1), y1c = min(Y1, SCREEN_H-1). X0/Y0 are taken as-is. Colour is latched.
- SETUP:
  - If X0 > x1c, or Y0 > y1c, or X0 ≥ SCREEN_W, or Y0 ≥ SCREEN_H, go to DONE with no pixels.
  - Otherwise set cx = X0, cy = Y0, row_base = Y0*SCREEN_W, fb_addr = row_base + X0, and go to DRAW.
- DRAW: `fb_valid` = 1. On a handshake:
  - If cx ≠ x1c: cx++, fb_addr++.
  - Else if cy ≠ y1c: cx = X0, cy++, row_base += SCREEN_W, fb_addr = row_base + SCREEN_W + X0.
  - Else go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Raster order: row-major, left to right, top to bottom.
- Arithmetic: `row_base` and `fb_addr` are FB_AW wide. They never exceed SCREEN_W*SCREEN_H-1 because of clipping.

## Timing
- Reset values: fb_valid 0, fb_addr 0, fb_data 0, busy 0, done 0, status 0, all registers 0, state IDLE. Reset mid-draw returns to IDLE at once and drops `fb_valid` without completing the handshake.
- Start store sampled at edge N. SETUP during cycle N+1. `fb_valid` first high in cycle N+2. `busy` high from cycle N+1.
- With `fb_ready` held high: one pixel per cycle, and `done` pulses W*H + 2 cycles after the start edge (W, H = clipped width and height).
- Empty rectangle: `done` pulses in cycle N+2. `fb_valid` never rises.
- Backpressure: while `fb_valid && !fb_ready`, `fb_addr` and `fb_data` are held stable and `fb_valid` stays high.
- `busy` falls in the cycle after the `done` pulse. A start may be issued in that same IDLE cycle.

## Configuration
- `DRAW_ABORT_EN` defined:
  - A CTRL write with bit1 = 1 while busy is latched.
  - In SETUP it forces DONE.
  - In DRAW, the pending pixel completes its handshake and then the FSM goes to DONE. If `fb_valid` is not currently waiting on a handshake, it goes to DONE on the next edge.
  - `status[1]` (aborted) is set at DONE and cleared by the next start.
- `DRAW_ABORT_EN` undefined: CTRL bit1 is ignored, `status[1]` is tied 0, and no abort logic is synthesized.

## Test plan
- X0=2, Y0=3, X1=4, Y1=4, COLOR=0x1F, start, fb_ready=1 → six writes at addrs 1922, 1923, 1924, 2562, 2563, 2564, data 0x1F. `done` pulses 8 cycles after the start edge.
- Same rectangle, fb_ready toggling 1/0 each cycle → identical address/data sequence, with fb_addr/fb_data stable during every stall.
- X0=636, Y0=479, X1=700, Y1=900, start → four writes at 307196..307199, then `done`.
- X0=10, X1=5, start → no `fb_valid`, `done` in cycle N+2. Writes to X0..COLOR while busy leave the latched values unchanged.
- 100×100 fill, reset driven low after 37 pixels → fb_valid=0, busy=0, status=0 immediately. A new 1×1 start afterwards completes normally.
- With DRAW_ABORT_EN: 100×100 fill, CTRL=0x2 after 10 accepted pixels → at most one further pixel accepted, then `done` and status=0x2. Without the macro, the same stimulus produces all 10000 pixels and status=0x0.
